// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_arbiter_pkg : shared FSM encoding and requester IDs
// Revision: 1.0
// ---------------------------------------------------------------------------
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb2 : two-port round-robin winner select, one-hot output
// Revision: 1.0
// ---------------------------------------------------------------------------
module rr_arb2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win
);

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    win = 2'b00;
    if (req[PORT_CPU] && (!req[PORT_DMA] || (last_gnt == PORT_DMA))) begin
      win[PORT_CPU] = 1'b1;
    end else if (req[PORT_DMA]) begin
      win[PORT_DMA] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_arbiter : CPU/DMA round-robin arbiter for a single-port data memory
// Revision: 1.0
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [DATA_BITS-1:0] wdata0,
  input  logic [DATA_BITS-1:0] wdata1,
  input  logic                 we0,
  input  logic                 we1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [DATA_BITS-1:0] rdata0,
  output logic [DATA_BITS-1:0] rdata1,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_write,
  output logic                 mem_read_n,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  state_e                 state_q;
  logic                   last_gnt_q;
  logic                   owner_q;
  logic                   gnt0_q, gnt1_q;
  logic                   rvalid0_q, rvalid1_q;
  logic [DATA_BITS-1:0]   rdata0_q, rdata1_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [DATA_BITS-1:0]   mem_wdata_q;
  logic                   mem_write_q;
  logic                   mem_read_n_q;

  logic [1:0]             win;
  logic                   sel_dma;

  rr_arb2 u_rr_arb2 (
    .req      ({req1, req0}),
    .last_gnt (last_gnt_q),
    .win      (win)
  );

  assign sel_dma = win[PORT_DMA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_gnt_q   <= PORT_DMA;
      owner_q      <= PORT_CPU;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_write_q  <= 1'b0;
      mem_read_n_q <= 1'b1;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|win) begin
            mem_addr_q   <= sel_dma ? addr1  : addr0;
            mem_wdata_q  <= sel_dma ? wdata1 : wdata0;
            mem_write_q  <= sel_dma ? we1    : we0;
            mem_read_n_q <= 1'b0;
            gnt0_q       <= win[PORT_CPU];
            gnt1_q       <= win[PORT_DMA];
            last_gnt_q   <= sel_dma;
            owner_q      <= sel_dma;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_read_n_q <= 1'b1;
          mem_write_q  <= 1'b0;
          state_q      <= RESP;
        end
        RESP: begin
          // Memory returns read data, or echoes write data, in this cycle.
          if (owner_q == PORT_DMA) begin
            rdata1_q  <= mem_rdata;
            rvalid1_q <= 1'b1;
          end else begin
            rdata0_q  <= mem_rdata;
            rvalid0_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = mem_write_q;
  assign mem_read_n = mem_read_n_q;

endmodule
`default_nettype wire
